// File: rtl/nibble_add_sequencer.sv
// Drives a shared 4-bit ripple adder one nibble per clock, LSB first, to add wide operands.
// Optional macro SUB_MODE_EN adds a Sub input that turns the operation into A-B.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
`ifdef SUB_MODE_EN
  input  logic                 Sub,
`endif
  input  logic [4*NIBBLES-1:0] OpA,
  input  logic [4*NIBBLES-1:0] OpB,
  input  logic                 CinIn,
  output logic                 Busy,
  output logic                 Done,
  output logic [4*NIBBLES-1:0] Result,
  output logic                 CoutOut,
  output logic [3:0]           AdderX,
  output logic [3:0]           AdderY,
  output logic                 AdderCin,
  input  logic [3:0]           AdderSum,
  input  logic                 AdderCout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a, r_b, r_result;
  logic          r_cout;

  logic          w_last;
  logic [W-1:0]  w_b_in;
  logic          w_cin_in;
  logic [3:0]    w_a_nib, w_b_nib;

  // Subtraction is A + ~B + 1; the carry out then reads as "no borrow".
`ifdef SUB_MODE_EN
  assign w_b_in   = Sub ? ~OpB : OpB;
  assign w_cin_in = Sub ? 1'b1 : CinIn;
`else
  assign w_b_in   = OpB;
  assign w_cin_in = CinIn;
`endif

  assign w_last  = (r_idx == IW'(NIBBLES - 1));
  assign w_a_nib = 4'(r_a >> {r_idx, 2'b00});
  assign w_b_nib = 4'(r_b >> {r_idx, 2'b00});

  always_comb begin
    w_next   = r_state;
    Busy     = 1'b0;
    Done     = 1'b0;
    AdderX   = 4'h0;
    AdderY   = 4'h0;
    AdderCin = 1'b0;
    case (r_state)
      S_IDLE: if (Start) w_next = S_ADD;
      S_ADD: begin
        Busy     = 1'b1;
        AdderX   = w_a_nib;
        AdderY   = w_b_nib;
        AdderCin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (Start) begin
          r_a      <= OpA;
          r_b      <= w_b_in;
          r_carry  <= w_cin_in;
          r_idx    <= '0;
          r_result <= '0;
        end
        S_ADD: begin
          for (int i = 0; i < NIBBLES; i++)
            if (r_idx == IW'(i)) r_result[4*i +: 4] <= AdderSum;
          r_carry <= AdderCout;
          // idx wraps to 0 after the last nibble so it never points past the operand
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= AdderCout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result  = r_result;
  assign CoutOut = r_cout;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: behavioural model checked every cycle plus directed literals.
module tb_nibble_add_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start, CinIn, Sub;
  logic [W-1:0] OpA, OpB;
  logic         Busy, Done, CoutOut, AdderCin, AdderCout;
  logic [W-1:0] Result;
  logic [3:0]   AdderX, AdderY, AdderSum;

  logic         Start1, CinIn1;
  logic [3:0]   OpA1, OpB1, Result1, AdderX1, AdderY1, AdderSum1;
  logic         Busy1, Done1, CoutOut1, AdderCin1, AdderCout1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  // FourBitAdder stand-ins
  assign {AdderCout, AdderSum}   = 5'(AdderX)  + 5'(AdderY)  + 5'(AdderCin);
  assign {AdderCout1, AdderSum1} = 5'(AdderX1) + 5'(AdderY1) + 5'(AdderCin1);

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
`ifdef SUB_MODE_EN
    .Sub(Sub),
`endif
    .OpA(OpA), .OpB(OpB), .CinIn(CinIn),
    .Busy(Busy), .Done(Done), .Result(Result), .CoutOut(CoutOut),
    .AdderX(AdderX), .AdderY(AdderY), .AdderCin(AdderCin),
    .AdderSum(AdderSum), .AdderCout(AdderCout));

  nibble_add_sequencer #(.NIBBLES(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start1),
`ifdef SUB_MODE_EN
    .Sub(Sub),
`endif
    .OpA(OpA1), .OpB(OpB1), .CinIn(CinIn1),
    .Busy(Busy1), .Done(Done1), .Result(Result1), .CoutOut(CoutOut1),
    .AdderX(AdderX1), .AdderY(AdderY1), .AdderCin(AdderCin1),
    .AdderSum(AdderSum1), .AdderCout(AdderCout1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] msk(input int j);
    return (64'd1 << (4 * j)) - 64'd1;
  endfunction

  function automatic logic [63:0] model_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin);
    return a + b + 64'(cin);
  endfunction

  // Model: phase 0 idle, 1..N working on nibble phase-1, N+1 done.
  int          m_phase = 0;
  logic [63:0] m_a = 0, m_b = 0, m_sum = 0, m_held = 0;
  logic        m_cin = 0, m_cout = 0;

  initial forever begin
    logic [63:0] e_res, e_x, e_y, e_c;
    int j;
    @(negedge Clk);
    if (chk_en) begin
      j = m_phase - 1;
      if (m_phase >= 1 && m_phase <= N) begin
        e_res = m_sum & msk(j);
        e_x   = (m_a >> (4 * j)) & 64'hF;
        e_y   = (m_b >> (4 * j)) & 64'hF;
        e_c   = (((m_a & msk(j)) + (m_b & msk(j)) + 64'(m_cin)) >> (4 * j)) & 64'h1;
      end else begin
        e_res = m_held; e_x = 0; e_y = 0; e_c = 0;
      end
      check("busy",      64'(Busy),     64'(m_phase != 0));
      check("done",      64'(Done),     64'(m_phase == N + 1));
      check("result",    64'(Result),   e_res);
      check("cout",      64'(CoutOut),  64'(m_cout));
      check("adder_x",   64'(AdderX),   e_x);
      check("adder_y",   64'(AdderY),   e_y);
      check("adder_cin", 64'(AdderCin), e_c);
    end
    if (!Rst_n) begin
      m_phase = 0; m_held = 0; m_cout = 0;
    end else if (m_phase == 0) begin
      if (Start) begin
        m_a   = 64'(OpA);
        m_b   = 64'(OpB);
        m_cin = CinIn;
`ifdef SUB_MODE_EN
        if (Sub) begin m_b = (~m_b) & msk(N); m_cin = 1'b1; end
`endif
        m_sum   = model_sum(m_a, m_b, m_cin);
        m_held  = 0;
        m_phase = 1;
      end
    end else if (m_phase == N) begin
      m_held  = m_sum & msk(N);
      m_cout  = m_sum[W];
      m_phase = N + 1;
    end else if (m_phase == N + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  // Waits for Done after an accept edge; returns cycles counted from accept (first ADD = 1).
  task automatic wait_done(output int cyc);
    bit found = 0;
    cyc = 1;
    while (!found && cyc <= 20) begin
      @(negedge Clk);
      if (Done) found = 1;
      else begin @(posedge Clk); cyc++; end
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_res, input logic exp_cout, input string nm);
    int cyc;
    @(posedge Clk); #1;
    Start = 1; OpA = a; OpB = b; CinIn = cin;
    @(posedge Clk); #1;
    Start = 0;
    wait_done(cyc);
    check({nm, "_latency"}, 64'(cyc), 64'(N + 1));
    check({nm, "_result"},  64'(Result), 64'(exp_res));
    check({nm, "_cout"},    64'(CoutOut), 64'(exp_cout));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin @(negedge Clk); if (Done) cnt++; end
  endtask

  initial begin
    int cyc, cnt;
    logic [63:0] pin;
    Rst_n = 0; Start = 0; CinIn = 0; Sub = 0; OpA = 0; OpB = 0;
    Start1 = 0; CinIn1 = 0; OpA1 = 0; OpB1 = 0;

    // reset held for two clocks
    repeat (2) @(posedge Clk);
    #1 chk_en = 1;
    @(negedge Clk);
    check("rst_busy", 64'(Busy), 0);     check("rst_done", 64'(Done), 0);
    check("rst_result", 64'(Result), 0); check("rst_cout", 64'(CoutOut), 0);
    check("rst_x", 64'(AdderX), 0);      check("rst_y", 64'(AdderY), 0);
    check("rst_cin", 64'(AdderCin), 0);  check("rst_busy1", 64'(Busy1), 0);
    @(posedge Clk); #1 Rst_n = 1;

    // model pinned against hand sums
    pin = model_sum(64'h1234, 64'h4321, 1'b0);
    check("pin_5555", pin, 64'h5555);
    pin = model_sum(64'hFFFF, 64'h0000, 1'b1);
    check("pin_ripple", pin, 64'h1_0000);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb_carry");
    run_op(16'hA5C3, 16'h1B2D, 1'b1, 16'hC0F1, 1'b0, "mixed");

    // Start during ADD is ignored
    @(posedge Clk); #1;
    Start = 1; OpA = 16'h1234; OpB = 16'h4321; CinIn = 0;
    @(posedge Clk); #1 Start = 0;
    @(posedge Clk); #1 Start = 1; OpA = 16'h0001; OpB = 16'h0001;
    @(posedge Clk); #1 Start = 0;
    @(posedge Clk);
    wait_done(cyc);
    check("ign_result", 64'(Result), 64'h5555);
    count_dones(N + 4, cnt);
    check("ign_one_done", 64'(cnt), 0);
    check("ign_hold", 64'(Result), 64'h5555);

    // reset during the second ADD cycle aborts
    @(posedge Clk); #1;
    Start = 1; OpA = 16'h00FF; OpB = 16'h0001;
    @(posedge Clk); #1 Start = 0;
    @(posedge Clk); #1 Rst_n = 0;
    @(posedge Clk); #1 Rst_n = 1;
    @(negedge Clk);
    check("abort_busy", 64'(Busy), 0);     check("abort_result", 64'(Result), 0);
    check("abort_cout", 64'(CoutOut), 0);  check("abort_x", 64'(AdderX), 0);
    count_dones(N + 4, cnt);
    check("abort_no_done", 64'(cnt), 0);

    // Start held high: back-to-back every N+2 cycles
    @(posedge Clk); #1;
    Start = 1; OpA = 16'h0F0F; OpB = 16'h0101; CinIn = 0;
    count_dones(2 * (N + 2), cnt);
    #1 Start = 0;
    check("b2b_dones", 64'(cnt), 2);
    repeat (N + 3) @(posedge Clk);
    check("b2b_result", 64'(Result), 64'h1010);

`ifdef SUB_MODE_EN
    @(posedge Clk); #1;
    Sub = 1; Start = 1; OpA = 16'h0005; OpB = 16'h0007; CinIn = 0;
    @(posedge Clk); #1 Start = 0;
    wait_done(cyc);
    check("sub_result", 64'(Result), 64'hFFFE);
    check("sub_cout", 64'(CoutOut), 0);
`endif

    // single-nibble instance: 9 +/- 8 both give 1 with carry out
    @(posedge Clk); #1;
    Start1 = 1; OpA1 = 4'h9; OpB1 = 4'h8; CinIn1 = 0;
    @(posedge Clk); #1 Start1 = 0;
    cyc = 1;
    @(negedge Clk);
    while (!Done1 && cyc <= 10) begin @(posedge Clk); cyc++; @(negedge Clk); end
    check("n1_latency", 64'(cyc), 2);
    check("n1_result", 64'(Result1), 64'h1);
    check("n1_cout", 64'(CoutOut1), 1);
    Sub = 0;

    repeat (3) @(posedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
